// File: rtl/sum_accumulator_pkg.sv
// Shared types and width helpers for the sum_accumulator block.
// Imported by sum_accumulator and sum_accumulator_add.
package sum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Two guard bits cover a 4-sample frame of full-scale inputs without carry.
    function automatic int acc_width_f(input int width);
        return width + 2;
    endfunction

    // Counter must represent COUNT itself, hence COUNT+1 codes.
    function automatic int cnt_width_f(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/sum_accumulator_add.sv
// Combinational accumulator adder with zero-extended sample operand.
// SUM_ACCUMULATOR_SATURATE_EN selects clamp-to-max instead of modulo wrap.
module sum_accumulator_add #(
    parameter int WIDTH     = 2,
    parameter int ACC_WIDTH = 4
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]     sum_i,
    output logic [ACC_WIDTH-1:0] result_o,
    output logic                 overflow_o
);

    // Wide enough for the exact sum even if a sample is wider than the accumulator.
    localparam int SW = ((ACC_WIDTH > WIDTH) ? ACC_WIDTH : WIDTH) + 1;

    logic [SW-1:0] full_sum;

    always_comb begin
        full_sum   = SW'(acc_i) + SW'(sum_i);
        overflow_o = |full_sum[SW-1:ACC_WIDTH];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        result_o   = overflow_o ? {ACC_WIDTH{1'b1}} : full_sum[ACC_WIDTH-1:0];
`else
        result_o   = full_sum[ACC_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/sum_accumulator.sv
// Frames COUNT incoming sums into one total delivered over a valid/ready handshake.
// Overflow behaviour (wrap or saturate) follows SUM_ACCUMULATOR_SATURATE_EN.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = acc_width_f(WIDTH),
    parameter int CNT_WIDTH = cnt_width_f(COUNT)
) (
    input  logic                 IN_clk,
    input  logic                 IN_rst_n,
    input  logic                 IN_clear,
    input  logic                 IN_sum_valid,
    output logic                 OUT_sum_ready,
    input  logic [WIDTH-1:0]     IN_sum,
    output logic                 OUT_acc_valid,
    input  logic                 IN_acc_ready,
    output logic [ACC_WIDTH-1:0] OUT_acc,
    output logic [CNT_WIDTH-1:0] OUT_count,
    output logic                 OUT_overflow
);

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   ready_q, ready_d;

    logic [ACC_WIDTH-1:0]   add_result;
    logic                   add_overflow;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   accept;

    sum_accumulator_add #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .acc_i      (acc_q),
        .sum_i      (IN_sum),
        .result_o   (add_result),
        .overflow_o (add_overflow)
    );

    assign accept  = IN_sum_valid && ready_q;
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (IN_clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d   = add_result;
                        ovf_d   = ovf_q | add_overflow;
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == CNT_WIDTH'(COUNT)) ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (IN_acc_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end

        // Ready is registered so it stays low while reset is held.
        ready_d = (state_d != DONE);
    end

    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
        end
    end

    assign OUT_sum_ready = ready_q;
    assign OUT_acc_valid = (state_q == DONE);
    assign OUT_acc       = acc_q;
    assign OUT_count     = cnt_q;
    assign OUT_overflow  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: main (COUNT=4, ACC=4), overflow (ACC=3) and COUNT=1 instances.
module tb_sum_accumulator;

    logic       IN_clk       = 1'b0;
    logic       IN_rst_n     = 1'b0;
    logic       IN_clear     = 1'b0;
    logic       IN_acc_ready = 1'b0;
    logic [1:0] IN_sum       = 2'd0;
    logic       vld_m = 1'b0, vld_o = 1'b0, vld_c = 1'b0;

    logic       rdy_m, av_m, ovf_m;
    logic [3:0] acc_m;
    logic [2:0] cnt_m;
    logic       rdy_o, av_o, ovf_o;
    logic [2:0] acc_o;
    logic [2:0] cnt_o;
    logic       rdy_c, av_c, ovf_c;
    logic [3:0] acc_c;
    logic [0:0] cnt_c;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int s[4];
        int exp_acc;
        int exp_ovf;
    } vec_t;

    typedef struct {
        int acc;
        int ovf;
        int cnt;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];

    always #5 IN_clk = ~IN_clk;

    sum_accumulator #(.WIDTH(2), .COUNT(4)) dut_m (
        .IN_clk(IN_clk), .IN_rst_n(IN_rst_n), .IN_clear(IN_clear),
        .IN_sum_valid(vld_m), .OUT_sum_ready(rdy_m), .IN_sum(IN_sum),
        .OUT_acc_valid(av_m), .IN_acc_ready(IN_acc_ready), .OUT_acc(acc_m),
        .OUT_count(cnt_m), .OUT_overflow(ovf_m)
    );

    sum_accumulator #(.WIDTH(2), .COUNT(4), .ACC_WIDTH(3)) dut_o (
        .IN_clk(IN_clk), .IN_rst_n(IN_rst_n), .IN_clear(IN_clear),
        .IN_sum_valid(vld_o), .OUT_sum_ready(rdy_o), .IN_sum(IN_sum),
        .OUT_acc_valid(av_o), .IN_acc_ready(IN_acc_ready), .OUT_acc(acc_o),
        .OUT_count(cnt_o), .OUT_overflow(ovf_o)
    );

    sum_accumulator #(.WIDTH(2), .COUNT(1)) dut_c (
        .IN_clk(IN_clk), .IN_rst_n(IN_rst_n), .IN_clear(IN_clear),
        .IN_sum_valid(vld_c), .OUT_sum_ready(rdy_c), .IN_sum(IN_sum),
        .OUT_acc_valid(av_c), .IN_acc_ready(IN_acc_ready), .OUT_acc(acc_c),
        .OUT_count(cnt_c), .OUT_overflow(ovf_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge IN_clk);
        #1;
    endtask

    // Feeds four samples back-to-back into the main instance, checking the running values.
    task automatic feed_m(input int s[4]);
        int run;
        run = 0;
        for (int i = 0; i < 4; i++) begin
            IN_sum = s[i][1:0];
            vld_m  = 1'b1;
            check("main_ready_in_frame", rdy_m, 1);
            step();
            run += s[i];
            check("main_count_run", cnt_m, i + 1);
            check("main_acc_run", acc_m, run);
        end
        vld_m = 1'b0;
    endtask

    task automatic pop_main();
        exp_t e;
        if (sb.size() == 0) begin
            check("main_sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("main_total", acc_m, e.acc);
            check("main_overflow", ovf_m, e.ovf);
            check("main_count_done", cnt_m, e.cnt);
        end
    endtask

    initial begin
        int a[4];
        exp_t e;
        bit seen;

        vecs[0] = '{s: '{3, 3, 3, 3}, exp_acc: 12, exp_ovf: 0};
        vecs[1] = '{s: '{1, 2, 3, 0}, exp_acc: 6,  exp_ovf: 0};
        vecs[2] = '{s: '{0, 0, 0, 0}, exp_acc: 0,  exp_ovf: 0};
        vecs[3] = '{s: '{2, 3, 1, 3}, exp_acc: 9,  exp_ovf: 0};
        vecs[4] = '{s: '{0, 3, 0, 1}, exp_acc: 4,  exp_ovf: 0};

        // Power-on reset
        #12;
        check("reset_acc", acc_m, 0);
        check("reset_count", cnt_m, 0);
        check("reset_valid", av_m, 0);
        check("reset_ready_low", rdy_m, 0);
        @(negedge IN_clk);
        IN_rst_n = 1'b1;
        step();
        check("post_reset_ready", rdy_m, 1);
        check("post_reset_valid", av_m, 0);

        // Table-driven frames through the main instance
        for (int r = 0; r < 5; r++) begin
            sb.push_back('{acc: vecs[r].exp_acc, ovf: vecs[r].exp_ovf, cnt: 4});
            feed_m(vecs[r].s);
            check("main_valid_rise", av_m, 1);
            check("main_ready_done", rdy_m, 0);
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                if (av_m) seen = 1'b1;
                else step();
            end
            if (seen) pop_main();
            else check("main_valid_timeout", 0, 1);
            IN_acc_ready = 1'b1;
            step();
            IN_acc_ready = 1'b0;
            check("xfer_valid_low", av_m, 0);
            check("xfer_ready_high", rdy_m, 1);
            check("xfer_acc_zero", acc_m, 0);
            check("xfer_count_zero", cnt_m, 0);
        end

        // Backpressure in DONE with a held sample
        a = '{3, 3, 3, 3};
        feed_m(a);
        vld_m  = 1'b1;
        IN_sum = 2'd1;
        for (int j = 0; j < 3; j++) begin
            step();
            check("bp_ready_low", rdy_m, 0);
            check("bp_valid_held", av_m, 1);
            check("bp_acc_held", acc_m, 12);
            check("bp_count_held", cnt_m, 4);
        end
        IN_acc_ready = 1'b1;
        step();
        IN_acc_ready = 1'b0;
        check("bp_xfer_acc", acc_m, 0);
        check("bp_xfer_count", cnt_m, 0);
        check("bp_xfer_ready", rdy_m, 1);
        step();
        vld_m = 1'b0;
        check("bp_held_count", cnt_m, 1);
        check("bp_held_acc", acc_m, 1);
        IN_clear = 1'b1;
        step();
        IN_clear = 1'b0;
        check("bp_clear_count", cnt_m, 0);

        // Clear beats a simultaneous accept
        vld_m = 1'b1; IN_sum = 2'd2;
        step();
        IN_sum = 2'd1;
        step();
        check("clr_pre_count", cnt_m, 2);
        check("clr_pre_acc", acc_m, 3);
        IN_sum = 2'd3; IN_clear = 1'b1;
        step();
        IN_clear = 1'b0; vld_m = 1'b0;
        check("clr_count", cnt_m, 0);
        check("clr_acc", acc_m, 0);
        check("clr_ready", rdy_m, 1);
        step();
        check("clr_count_stays", cnt_m, 0);

        // Clear while DONE drops the held total
        a = '{1, 1, 1, 1};
        feed_m(a);
        IN_clear = 1'b1;
        step();
        IN_clear = 1'b0;
        check("clr_done_valid", av_m, 0);
        check("clr_done_acc", acc_m, 0);

        // Overflow instance, ACC_WIDTH=3
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        sb.push_back('{acc: 7, ovf: 1, cnt: 4});
`else
        sb.push_back('{acc: 4, ovf: 1, cnt: 4});
`endif
        vld_o = 1'b1; IN_sum = 2'd3;
        step();
        step();
        check("ovf_mid_acc", acc_o, 6);
        check("ovf_mid_flag", ovf_o, 0);
        step();
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        check("ovf_third_acc", acc_o, 7);
`else
        check("ovf_third_acc", acc_o, 1);
`endif
        check("ovf_third_flag", ovf_o, 1);
        step();
        vld_o = 1'b0;
        check("ovf_valid", av_o, 1);
        if (sb.size() == 0) begin
            check("ovf_sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("ovf_total", acc_o, e.acc);
            check("ovf_flag_sticky", ovf_o, e.ovf);
            check("ovf_count", cnt_o, e.cnt);
        end
        IN_acc_ready = 1'b1;
        step();
        IN_acc_ready = 1'b0;
        check("ovf_flag_cleared", ovf_o, 0);
        check("ovf_acc_cleared", acc_o, 0);

        // COUNT=1 instance
        vld_c = 1'b1; IN_sum = 2'd2;
        check("c1_ready", rdy_c, 1);
        step();
        vld_c = 1'b0;
        check("c1_valid", av_c, 1);
        check("c1_acc", acc_c, 2);
        check("c1_count", cnt_c, 1);
        check("c1_ready_done", rdy_c, 0);
        IN_acc_ready = 1'b1;
        step();
        IN_acc_ready = 1'b0;
        check("c1_xfer_valid", av_c, 0);
        check("c1_xfer_count", cnt_c, 0);
        check("c1_xfer_ready", rdy_c, 1);

        // Asynchronous reset mid-frame
        vld_m = 1'b1; IN_sum = 2'd1;
        step();
        step();
        vld_m = 1'b0;
        check("rst_pre_count", cnt_m, 2);
        #2;
        IN_rst_n = 1'b0;
        #1;
        check("rst_async_acc", acc_m, 0);
        check("rst_async_count", cnt_m, 0);
        check("rst_async_valid", av_m, 0);
        check("rst_async_ovf", ovf_m, 0);
        check("rst_async_ready", rdy_m, 0);
        @(negedge IN_clk);
        @(negedge IN_clk);
        IN_rst_n = 1'b1;
        step();
        check("rst_release_ready", rdy_m, 1);
        check("rst_release_count", cnt_m, 0);
        vld_m = 1'b1; IN_sum = 2'd2;
        step();
        vld_m = 1'b0;
        check("rst_restart_count", cnt_m, 1);
        check("rst_restart_acc", acc_m, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
